// File: rtl/jtfm_slotreg.sv
// jtfm_slotreg: time-multiplexed FM operator register file with queued host writes and a RAM-clear sweep.
// Define JTFM_SLOTREG_RDBK_EN to add the rd_* read-back port.
module jtfm_slotreg #(
  parameter int CH_W = 3,
  parameter int OP_W = 2,
  parameter int LANES = 6,
  parameter logic [3*LANES-1:0] LANE_OFS = '0,
  localparam int SLOT_W = CH_W + OP_W,
  localparam int SLOTS = 1 << SLOT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic               wr_req,
  input  logic [SLOT_W-1:0]  wr_slot,
  input  logic [2:0]         wr_lane,
  input  logic [7:0]         wr_data,
  output logic               busy,
  output logic [SLOT_W-1:0]  cur_slot,
  output logic               zero,
`ifdef JTFM_SLOTREG_RDBK_EN
  input  logic               rd_req,
  input  logic [SLOT_W-1:0]  rd_slot,
  input  logic [2:0]         rd_lane,
  output logic               rd_valid,
  output logic [7:0]         rd_data,
`endif
  output logic [8*LANES-1:0] lane_out
);
  typedef enum logic [1:0] {INIT, IDLE, PEND} state_t;
  state_t state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d, wr_slot_q, wr_slot_d;
  logic [2:0] wr_lane_q, wr_lane_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [8*LANES-1:0] ram [SLOTS];
  logic [8*LANES-1:0] ram_q, row_wd;
  logic capture, commit;
  // Slot at which lane l presents logical slot s; out-of-range lanes use offset 0.
  function automatic logic [SLOT_W-1:0] stage(input logic [SLOT_W-1:0] s, input logic [2:0] l);
    return (int'(l) < LANES) ? s + SLOT_W'(LANE_OFS[3*int'(l) +: 3]) : s;
  endfunction
  always_comb begin
    commit = clk_en && state_q == PEND && slot_q == stage(wr_slot_q, wr_lane_q);
    capture = state_q == IDLE && wr_req;
    slot_d = clk_en ? slot_q + SLOT_W'(1) : slot_q;
    state_d = state_q == INIT ? ((clk_en && &slot_q) ? IDLE : INIT)
            : state_q == IDLE ? (wr_req ? PEND : IDLE)
            : (commit ? IDLE : PEND);
    wr_slot_d = capture ? wr_slot : wr_slot_q;
    wr_lane_d = capture ? wr_lane : wr_lane_q;
    wr_data_d = capture ? wr_data : wr_data_q;
    row_wd = state_q == INIT ? '0 : lane_out;
    if (commit && int'(wr_lane_q) < LANES) row_wd[8*int'(wr_lane_q) +: 8] = wr_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      slot_q    <= '0;
      ram_q     <= '0;
      wr_slot_q <= '0;
      wr_lane_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      ram_q     <= clk_en ? ram[slot_d] : ram_q;
      wr_slot_q <= wr_slot_d;
      wr_lane_q <= wr_lane_d;
      wr_data_q <= wr_data_d;
    end
  end
  always_ff @(posedge clk) if (clk_en) ram[slot_q] <= row_wd;
  assign lane_out = state_q == INIT ? '0 : ram_q;
  assign busy = state_q != IDLE;
  assign cur_slot = slot_q;
  assign zero = slot_q == '0;
`ifdef JTFM_SLOTREG_RDBK_EN
  logic rd_pend_q, rd_pend_d, rd_valid_q, rd_valid_d, rd_hit;
  logic [SLOT_W-1:0] rd_slot_q, rd_slot_d;
  logic [2:0] rd_lane_q, rd_lane_d;
  logic [7:0] rd_data_q, rd_data_d;
  // Sampling lane_out before the write-back lands gives the old value on a same-cycle commit.
  always_comb begin
    rd_hit = clk_en && rd_pend_q && slot_q == stage(rd_slot_q, rd_lane_q);
    rd_pend_d = rd_pend_q ? !rd_hit : rd_req;
    rd_slot_d = (!rd_pend_q && rd_req) ? rd_slot : rd_slot_q;
    rd_lane_d = (!rd_pend_q && rd_req) ? rd_lane : rd_lane_q;
    rd_valid_d = rd_hit;
    rd_data_d = !rd_hit ? rd_data_q : (int'(rd_lane_q) < LANES) ? lane_out[8*int'(rd_lane_q) +: 8] : 8'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q  <= 1'b0;
      rd_slot_q  <= '0;
      rd_lane_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_slot_q  <= rd_slot_d;
      rd_lane_q  <= rd_lane_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end
  assign rd_valid = rd_valid_q;
  assign rd_data = rd_data_q;
`endif
endmodule
